operand_bypass_network: RTL
===========================

# operand_bypass_network

Parametrised operand forwarding and hazard unit between decode and execute. It replaces the fixed three-source forwarding path with three kinds of source: NUM_STAGES in-flight producer stages, the live register-file write port, and a WB_HIST_DEPTH-deep history of committed writes that covers register-file read latency. Each source is resolved by strict priority. The unit adds load-use stall generation, a stall watchdog and optional performance counters.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; REG_ADDR_W = $clog2(NUM_REGS)
- XLEN, 32, data width
- NUM_STAGES, 2, producer stages after decode; index 0 is youngest (execute output)
- WB_HIST_DEPTH, 1, registered copies of past write-port transactions (0 allowed)
- MAX_STALL, 15, consecutive stall cycles before watchdog trips (≥1)

SRC_W = $clog2(NUM_STAGES+WB_HIST_DEPTH+2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  consumer instruction present
- id_rs1, id_rs2  in  REG_ADDR_W  source register indices
- id_use_rs1, id_use_rs2  in  1  operand actually read by opcode
- id_rs1_value, id_rs2_value  in  XLEN  register-file read data
- prod_valid  in  NUM_STAGES  stage holds a register-writing instruction
- prod_rd  in  NUM_STAGES*REG_ADDR_W  destination per stage, packed, stage 0 in LSBs
- prod_data  in  NUM_STAGES*XLEN  result per stage, packed
- prod_ready  in  NUM_STAGES  result valid (0 = load data not yet returned)
- wb_en, wb_addr, wb_data  in  1/REG_ADDR_W/XLEN  register-file write port
- rs1_value, rs2_value  out  XLEN  resolved operands
- fwd_src1, fwd_src2  out  SRC_W  selected source: 0 regfile, k=1..NUM_STAGES stage k-1, NUM_STAGES+1 live write port, NUM_STAGES+2+j history entry j
- stall  out  1  hold decode/execute boundary
- stall_timeout  out  1  sticky watchdog flag
- perf_fwd_count, perf_stall_count  out  32  counters (see Configuration)

## Operation
- Per operand, a source matches when all of the following hold: id_valid, use flag 1, rs≠0, source valid, destination == rs.
- Priority: stage 0 > stage 1 > … > live write port > history 0 (newest) > … > regfile. The highest-priority match wins even if a lower one also matches.
- rs==0 or use flag 0: value = id_rs*_value, fwd_src = 0. Producers writing x0 are never forwarded.
- Winning producer stage with prod_ready=0: stall=1 and operand value is don't-care. Lower-priority matches must not mask this stall.
- stall = OR over both operands of not-ready winning matches. It is 0 whenever id_valid=0.
- History: a shift register. Each cycle entry 0 ← {wb_en, wb_addr, wb_data} and entry j ← entry j-1. It shifts regardless of stall.
- Watchdog: a consecutive-stall counter increments while stall=1 and clears when stall=0. When it reaches MAX_STALL, stall_timeout sets. It stays set until rst, and stall behaviour is unchanged.

## Timing
- Forwarding and stall are combinational from inputs and history. Latency is 0 cycles.
- A write on wb at cycle t is visible via the live port at t and via history entry j at t+1+j.
- Reset: history valid bits 0, stall counter 0, stall_timeout 0, perf counters 0. Data registers need no reset. Post-reset outputs: fwd_src = 0, rs*_value = regfile inputs, stall = 0 unless a producer match demands it.
- Reset asserted mid-stall: counter and flag clear on the next edge. History is empty in the first cycle after rst deasserts.
- Simultaneous stage and live-port match with equal data: the stage still wins, and fwd_src reports the stage.

## Configuration
- BYPASS_PERF_COUNTERS_EN defined:
  - perf_fwd_count increments on cycles with id_valid=1, stall=0 and at least one fwd_src≠0.
  - perf_stall_count increments on stall=1 cycles.
  - Both wrap modulo 2^32.
- Not defined: both outputs are constant 0 and no counter flops are synthesised.

## Test plan
- Stage0 rd=5 data=0x11, stage1 rd=5 data=0x22, id_rs1=5 use=1 → rs1_value=0x11, fwd_src1=1, stall=0.
- Stage0 rd=7 prod_ready=0, id_rs2=7 use=1 → stall=1. Next cycle ready=1, data=0xAB → stall=0, rs2_value=0xAB.
- wb_en=1 addr=3 data=0x55 at t, WB_HIST_DEPTH=1, no producers → at t fwd_src=NUM_STAGES+1; at t+1 rs1_value=0x55 with fwd_src=NUM_STAGES+2; at t+2 regfile value.
- id_rs1=0 and stage0 rd=0 data=0xFF → rs1_value=id_rs1_value, fwd_src1=0. Use flag 0 with a matching rd → no forward, no stall.
- Hold a not-ready match for MAX_STALL=15 cycles → stall_timeout=1 at cycle 15 and stays 1 after the stall clears. rst → 0.
- With the macro: 3 forwarded cycles plus 2 stall cycles → perf_fwd_count=3, perf_stall_count=2. Without it → both 0.

Source files
------------

// File: rtl/operand_bypass_network.sv
// Operand forwarding and load-use hazard unit between decode and execute.
// Optional perf counters are enabled by defining BYPASS_PERF_COUNTERS_EN.
module operand_bypass_network #(
  parameter int NUM_REGS      = 32,
  parameter int XLEN          = 32,
  parameter int NUM_STAGES    = 2,
  parameter int WB_HIST_DEPTH = 1,
  parameter int MAX_STALL     = 15,
  localparam int REG_ADDR_W   = $clog2(NUM_REGS),
  localparam int SRC_W        = $clog2(NUM_STAGES + WB_HIST_DEPTH + 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_ADDR_W-1:0]        id_rs1,
  input  logic [REG_ADDR_W-1:0]        id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic [XLEN-1:0]              id_rs1_value,
  input  logic [XLEN-1:0]              id_rs2_value,
  input  logic [NUM_STAGES-1:0]        prod_valid,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] prod_rd,
  input  logic [NUM_STAGES*XLEN-1:0]   prod_data,
  input  logic [NUM_STAGES-1:0]        prod_ready,
  input  logic                         wb_en,
  input  logic [REG_ADDR_W-1:0]        wb_addr,
  input  logic [XLEN-1:0]              wb_data,
  output logic [XLEN-1:0]              rs1_value,
  output logic [XLEN-1:0]              rs2_value,
  output logic [SRC_W-1:0]             fwd_src1,
  output logic [SRC_W-1:0]             fwd_src2,
  output logic                         stall,
  output logic                         stall_timeout,
  output logic [31:0]                  perf_fwd_count,
  output logic [31:0]                  perf_stall_count
);

  // A zero-depth history still gets one storage slot; the lookup loop never reads it.
  localparam int HIST_N = (WB_HIST_DEPTH > 0) ? WB_HIST_DEPTH : 1;
  localparam int CNT_W  = $clog2(MAX_STALL + 1);

  logic [HIST_N-1:0]     hist_vld_q, hist_vld_d;
  logic [REG_ADDR_W-1:0] hist_addr_q [HIST_N];
  logic [XLEN-1:0]       hist_data_q [HIST_N];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;

  logic [REG_ADDR_W-1:0] op_rs   [2];
  logic                  op_use  [2];
  logic [XLEN-1:0]       op_rf   [2];
  logic [XLEN-1:0]       op_val  [2];
  logic [SRC_W-1:0]      op_src  [2];
  logic                  op_nrdy [2];

  assign op_rs[0]  = id_rs1;
  assign op_rs[1]  = id_rs2;
  assign op_use[0] = id_use_rs1;
  assign op_use[1] = id_use_rs2;
  assign op_rf[0]  = id_rs1_value;
  assign op_rf[1]  = id_rs2_value;

  always_comb begin
    hist_vld_d    = hist_vld_q;
    hist_vld_d[0] = wb_en;
    for (int j = 1; j < HIST_N; j++) hist_vld_d[j] = hist_vld_q[j-1];
  end

  always_ff @(posedge clk) begin
    hist_addr_q[0] <= wb_addr;
    hist_data_q[0] <= wb_data;
    for (int j = 1; j < HIST_N; j++) begin
      hist_addr_q[j] <= hist_addr_q[j-1];
      hist_data_q[j] <= hist_data_q[j-1];
    end
  end

  // Sources are scanned lowest priority first so the highest-priority match overwrites.
  always_comb begin
    for (int op = 0; op < 2; op++) begin
      logic en;
      en          = id_valid && op_use[op] && (op_rs[op] != '0);
      op_val[op]  = op_rf[op];
      op_src[op]  = '0;
      op_nrdy[op] = 1'b0;
      for (int j = WB_HIST_DEPTH - 1; j >= 0; j--) begin
        if (en && hist_vld_q[j] && (hist_addr_q[j] == op_rs[op])) begin
          op_val[op]  = hist_data_q[j];
          op_src[op]  = SRC_W'(NUM_STAGES + 2 + j);
          op_nrdy[op] = 1'b0;
        end
      end
      if (en && wb_en && (wb_addr == op_rs[op])) begin
        op_val[op]  = wb_data;
        op_src[op]  = SRC_W'(NUM_STAGES + 1);
        op_nrdy[op] = 1'b0;
      end
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (en && prod_valid[k] && (prod_rd[k*REG_ADDR_W +: REG_ADDR_W] == op_rs[op])) begin
          op_val[op]  = prod_data[k*XLEN +: XLEN];
          op_src[op]  = SRC_W'(k + 1);
          op_nrdy[op] = ~prod_ready[k];
        end
      end
    end
  end

  assign rs1_value = op_val[0];
  assign rs2_value = op_val[1];
  assign fwd_src1  = op_src[0];
  assign fwd_src2  = op_src[1];
  assign stall     = op_nrdy[0] | op_nrdy[1];

  // Counter saturates at MAX_STALL; the flag is sticky until reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    if (stall) begin
      if (stall_cnt_q != CNT_W'(MAX_STALL)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = '0;
    end
    if (stall_cnt_d == CNT_W'(MAX_STALL)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      hist_vld_q  <= hist_vld_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;

`ifdef BYPASS_PERF_COUNTERS_EN
  logic [31:0] perf_fwd_q, perf_fwd_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fwd_d   = perf_fwd_q;
    perf_stall_d = perf_stall_q;
    if (id_valid && !stall && ((op_src[0] != '0) || (op_src[1] != '0)))
      perf_fwd_d = perf_fwd_q + 32'd1;
    if (stall) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fwd_q   <= perf_fwd_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fwd_count   = perf_fwd_q;
  assign perf_stall_count = perf_stall_q;
`else
  assign perf_fwd_count   = 32'd0;
  assign perf_stall_count = 32'd0;
`endif

endmodule
